// File: rtl/clk_div_ctrl_if.sv
// Divide-factor update channel: valid/ready handshake carrying a new divide factor.
interface clk_div_ctrl_if #(
    parameter int unsigned CTR_WIDTH = 24
) ();
    logic [CTR_WIDTH-1:0] div_val;
    logic                 div_valid;
    logic                 div_ready;

    modport master (
        output div_val,
        output div_valid,
        input  div_ready
    );

    modport slave (
        input  div_val,
        input  div_valid,
        output div_ready
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Run/stop controller and glitch-free reprogrammable divider for derived clocks.
// New factors take effect only at half-period boundaries; stop parks clk_out low.
module clk_div_ctrl #(
    parameter int unsigned CTR_WIDTH   = 24,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          en,
    clk_div_ctrl_if.slave div_if,
    output logic          clk_out,
    output logic          tick,
    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    localparam logic [CTR_WIDTH-1:0] One      = CTR_WIDTH'(1);
    localparam logic [CTR_WIDTH-1:0] ResetDiv = (DEFAULT_DIV == 0) ? One : CTR_WIDTH'(DEFAULT_DIV);

    state_e               state_q;
    logic [CTR_WIDTH-1:0] ctr_q;
    logic [CTR_WIDTH-1:0] div_cur_q;
    logic [CTR_WIDTH-1:0] pending_q;
    logic                 pending_valid_q;
    logic                 clk_out_q;
    logic                 tick_q;
    logic                 busy_q;

    logic                 accept;
    logic                 boundary;
    logic [CTR_WIDTH-1:0] div_clamped;

    assign accept      = div_if.div_valid && div_if.div_ready;
    assign boundary    = (ctr_q == div_cur_q);
    assign div_clamped = (div_if.div_val == '0) ? One : div_if.div_val;

    // Ready is a direct flop output: one pending slot, free whenever it is empty.
    assign div_if.div_ready = !pending_valid_q;
    assign clk_out          = clk_out_q;
    assign tick             = tick_q;
    assign busy             = busy_q;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            ctr_q           <= One;
            div_cur_q       <= ResetDiv;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            clk_out_q       <= 1'b0;
            tick_q          <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    ctr_q     <= One;
                    clk_out_q <= 1'b0;
                    // A value left pending by a low-phase stop is applied here.
                    if (pending_valid_q) begin
                        div_cur_q       <= pending_q;
                        pending_valid_q <= 1'b0;
                    end else if (accept) begin
                        div_cur_q <= div_clamped;
                    end
                    if (en) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                    end
                end
                StRun, StStop: begin
                    if (accept) begin
                        pending_q       <= div_clamped;
                        pending_valid_q <= 1'b1;
                    end
                    if (!en && !clk_out_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        ctr_q   <= One;
                    end else if (boundary) begin
                        // Here either en is high or clk_out is high, so a stop only ever falls.
                        clk_out_q <= !clk_out_q;
                        tick_q    <= !clk_out_q;
                        ctr_q     <= One;
                        if (pending_valid_q) begin
                            div_cur_q       <= pending_q;
                            pending_valid_q <= 1'b0;
                        end
                        if (en) begin
                            state_q <= StRun;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        ctr_q   <= ctr_q + One;
                        state_q <= en ? StRun : StStop;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus randomized run
// against a half-period-level reference model.
module tb_clk_div_ctrl;

    localparam int unsigned W   = 8;
    localparam int unsigned DEF = 3;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;
    logic en     = 1'b0;
    logic clk_out;
    logic tick;
    logic busy;

    int total = 0;
    int bad   = 0;

    clk_div_ctrl_if #(.CTR_WIDTH(W)) dif ();

    clk_div_ctrl #(
        .CTR_WIDTH  (W),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (en),
        .div_if (dif),
        .clk_out(clk_out),
        .tick   (tick),
        .busy   (busy)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: output level, position within the current half-period,
    // half-period length and a single queued factor.
    logic        m_active;
    logic        m_level;
    logic        m_tick;
    int unsigned m_elapsed;
    int unsigned m_factor;
    logic        m_pend_have;
    int unsigned m_pend;
    logic        m_ready;

    assign m_ready = !m_pend_have;

    function automatic int unsigned clamp(input logic [W-1:0] v);
        return (v == 0) ? 1 : int'(v);
    endfunction

    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            m_active    <= 1'b0;
            m_level     <= 1'b0;
            m_tick      <= 1'b0;
            m_elapsed   <= 1;
            m_factor    <= DEF;
            m_pend_have <= 1'b0;
            m_pend      <= 0;
        end else begin
            m_tick <= 1'b0;
            if (!m_active) begin
                m_level   <= 1'b0;
                m_elapsed <= 1;
                m_active  <= en;
                if (m_pend_have) begin
                    m_factor    <= m_pend;
                    m_pend_have <= 1'b0;
                end else if (dif.div_valid && m_ready) begin
                    m_factor <= clamp(dif.div_val);
                end
            end else begin
                if (en || m_level) begin
                    if (m_elapsed == m_factor) begin
                        m_elapsed <= 1;
                        m_level   <= !m_level;
                        m_tick    <= !m_level;
                        m_active  <= en;
                        if (m_pend_have) begin
                            m_factor    <= m_pend;
                            m_pend_have <= 1'b0;
                        end
                    end else begin
                        m_elapsed <= m_elapsed + 1;
                    end
                end else begin
                    m_active  <= 1'b0;
                    m_elapsed <= 1;
                end
                if (dif.div_valid && m_ready) begin
                    m_pend      <= clamp(dif.div_val);
                    m_pend_have <= 1'b1;
                end
            end
        end
    end

    // Each task starts and ends just after a falling edge.
    task automatic test_reset();
        dif.div_valid = 1'b0;
        dif.div_val   = '0;
        #2 rst = 1'b1;
        #1;
        total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL rst_clk_out: got %b want 0", clk_out); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL rst_tick: got %b want 0", tick); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (dif.div_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", dif.div_ready); end
        @(negedge clk_in);
        rst = 1'b0;
    endtask

    task automatic test_default_period();
        logic ec, et;
        en = 1'b1;
        @(negedge clk_in);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy: got %b want 1", busy); end
        total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL start_clk: got %b want 0", clk_out); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL pre_rise %0d: got %b want 0", i, clk_out); end
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_in);
            ec = ((i % 6) < 3);
            et = ((i % 6) == 0);
            total++; if (clk_out !== ec) begin bad++; $display("FAIL def_clk %0d: got %b want %b", i, clk_out, ec); end
            total++; if (tick !== et) begin bad++; $display("FAIL def_tick %0d: got %b want %b", i, tick, et); end
        end
    endtask

    task automatic test_reprogram();
        logic ec, et;
        @(negedge clk_in);
        total++; if (clk_out !== 1'b1 || tick !== 1'b1) begin bad++; $display("FAIL rp_rise: got clk=%b tick=%b want 1 1", clk_out, tick); end
        dif.div_valid = 1'b1;
        dif.div_val   = W'(5);
        @(negedge clk_in);
        dif.div_valid = 1'b0;
        total++; if (dif.div_ready !== 1'b0) begin bad++; $display("FAIL rp_ready_low: got %b want 0", dif.div_ready); end
        @(negedge clk_in);
        total++; if (clk_out !== 1'b1) begin bad++; $display("FAIL rp_old_half: got %b want 1", clk_out); end
        @(negedge clk_in);
        total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL rp_fall: got %b want 0", clk_out); end
        total++; if (dif.div_ready !== 1'b1) begin bad++; $display("FAIL rp_ready_back: got %b want 1", dif.div_ready); end
        for (int k = 0; k < 14; k++) begin
            @(negedge clk_in);
            ec = (((k + 1) % 10) >= 5);
            et = (((k + 1) % 10) == 5);
            total++; if (clk_out !== ec) begin bad++; $display("FAIL rp_clk %0d: got %b want %b", k, clk_out, ec); end
            total++; if (tick !== et) begin bad++; $display("FAIL rp_tick %0d: got %b want %b", k, tick, et); end
        end
    endtask

    task automatic test_stop_low();
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL sl_busy %0d: got %b want 0", i, busy); end
            total++; if (clk_out !== 1'b0 || tick !== 1'b0) begin bad++; $display("FAIL sl_out %0d: got clk=%b tick=%b want 0 0", i, clk_out, tick); end
        end
    endtask

    task automatic test_div_zero();
        logic e;
        dif.div_valid = 1'b1;
        dif.div_val   = '0;
        @(negedge clk_in);
        dif.div_valid = 1'b0;
        total++; if (dif.div_ready !== 1'b1) begin bad++; $display("FAIL dz_ready: got %b want 1", dif.div_ready); end
        en = 1'b1;
        @(negedge clk_in);
        total++; if (busy !== 1'b1 || clk_out !== 1'b0) begin bad++; $display("FAIL dz_start: got busy=%b clk=%b want 1 0", busy, clk_out); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            e = ((k % 2) == 0);
            total++; if (clk_out !== e) begin bad++; $display("FAIL dz_clk %0d: got %b want %b", k, clk_out, e); end
            total++; if (tick !== e) begin bad++; $display("FAIL dz_tick %0d: got %b want %b", k, tick, e); end
        end
    endtask

    task automatic test_stop_high();
        dif.div_valid = 1'b1;
        dif.div_val   = W'(4);
        @(negedge clk_in);
        dif.div_valid = 1'b0;
        total++; if (clk_out !== 1'b1 || dif.div_ready !== 1'b0) begin bad++; $display("FAIL sh_accept: got clk=%b rdy=%b want 1 0", clk_out, dif.div_ready); end
        @(negedge clk_in);
        total++; if (clk_out !== 1'b0 || dif.div_ready !== 1'b1) begin bad++; $display("FAIL sh_apply: got clk=%b rdy=%b want 0 1", clk_out, dif.div_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL sh_low %0d: got %b want 0", i, clk_out); end
        end
        @(negedge clk_in);
        total++; if (clk_out !== 1'b1 || tick !== 1'b1) begin bad++; $display("FAIL sh_rise: got clk=%b tick=%b want 1 1", clk_out, tick); end
        @(negedge clk_in);
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_in);
            total++; if (clk_out !== 1'b1 || busy !== 1'b1 || tick !== 1'b0) begin bad++; $display("FAIL sh_hold %0d: got clk=%b busy=%b tick=%b want 1 1 0", i, clk_out, busy, tick); end
        end
        @(negedge clk_in);
        total++; if (clk_out !== 1'b0 || busy !== 1'b0 || tick !== 1'b0) begin bad++; $display("FAIL sh_park: got clk=%b busy=%b tick=%b want 0 0 0", clk_out, busy, tick); end
        @(negedge clk_in);
        total++; if (clk_out !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL sh_idle: got clk=%b busy=%b want 0 0", clk_out, busy); end
    endtask

    task automatic test_restart_in_stop();
        en = 1'b1;
        @(negedge clk_in);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rs_busy: got %b want 1", busy); end
        repeat (3) @(negedge clk_in);
        @(negedge clk_in);
        total++; if (clk_out !== 1'b1 || tick !== 1'b1) begin bad++; $display("FAIL rs_rise: got clk=%b tick=%b want 1 1", clk_out, tick); end
        @(negedge clk_in);
        en = 1'b0;
        @(negedge clk_in);
        en = 1'b1;
        total++; if (clk_out !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL rs_stop: got clk=%b busy=%b want 1 1", clk_out, busy); end
        @(negedge clk_in);
        total++; if (clk_out !== 1'b1) begin bad++; $display("FAIL rs_cont_high: got %b want 1", clk_out); end
        @(negedge clk_in);
        total++; if (clk_out !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rs_fall: got clk=%b busy=%b want 0 1", clk_out, busy); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL rs_low %0d: got %b want 0", i, clk_out); end
        end
        @(negedge clk_in);
        total++; if (clk_out !== 1'b1 || tick !== 1'b1) begin bad++; $display("FAIL rs_rise2: got clk=%b tick=%b want 1 1", clk_out, tick); end
    endtask

    task automatic test_reset_mid_run();
        logic ec, et;
        dif.div_valid = 1'b1;
        dif.div_val   = W'(7);
        @(negedge clk_in);
        dif.div_valid = 1'b0;
        total++; if (dif.div_ready !== 1'b0) begin bad++; $display("FAIL rm_pending: got %b want 0", dif.div_ready); end
        #2 rst = 1'b1;
        #1;
        total++; if (clk_out !== 1'b0 || tick !== 1'b0) begin bad++; $display("FAIL rm_out: got clk=%b tick=%b want 0 0", clk_out, tick); end
        total++; if (busy !== 1'b0 || dif.div_ready !== 1'b1) begin bad++; $display("FAIL rm_ctl: got busy=%b rdy=%b want 0 1", busy, dif.div_ready); end
        @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        total++; if (busy !== 1'b1 || clk_out !== 1'b0) begin bad++; $display("FAIL rm_start: got busy=%b clk=%b want 1 0", busy, clk_out); end
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk_in);
            ec = (t >= 3) && (((t - 3) % 6) < 3);
            et = (t >= 3) && (((t - 3) % 6) == 0);
            total++; if (clk_out !== ec || tick !== et) begin bad++; $display("FAIL rm_period %0d: got clk=%b tick=%b want %b %b", t, clk_out, tick, ec, et); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            en            = ($urandom_range(0, 99) < 85);
            dif.div_valid = ($urandom_range(0, 99) < 20);
            dif.div_val   = W'($urandom_range(0, 6));
            @(negedge clk_in);
            total++; if (clk_out !== m_level) begin bad++; $display("FAIL rnd_clk %0d: got %b want %b", n, clk_out, m_level); end
            total++; if (tick !== m_tick) begin bad++; $display("FAIL rnd_tick %0d: got %b want %b", n, tick, m_tick); end
            total++; if (busy !== m_active) begin bad++; $display("FAIL rnd_busy %0d: got %b want %b", n, busy, m_active); end
            total++; if (dif.div_ready !== m_ready) begin bad++; $display("FAIL rnd_ready %0d: got %b want %b", n, dif.div_ready, m_ready); end
        end
        dif.div_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_reprogram();
        test_stop_low();
        test_div_zero();
        test_stop_high();
        test_restart_in_stop();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
